// File: rtl/avg_seq_ctrl_if.sv
// Bus between the averaging sequencer, the FIFO read side, the accumulator and the result RAM.
// Strobe semantics: rd_fifo is a read request honoured in the same cycle and its data is valid
// one cycle later; accum_en, wr_ram and restart_avg are single-cycle strobes with no back-pressure.
interface avg_seq_ctrl_if #(
  parameter int ADDR_W = 8
);
  logic              enable;
  logic              empty_flag;
  logic              rd_fifo;
  logic              accum_en;
  logic              wr_ram;
  logic [ADDR_W-1:0] ram_addr;
  logic              restart_avg;
  logic              ram_full;
  logic              busy;
  logic [2:0]        state_dbg;

  modport master (
    input  enable, empty_flag,
    output rd_fifo, accum_en, wr_ram, ram_addr, restart_avg, ram_full, busy, state_dbg
  );

  modport slave (
    output enable, empty_flag,
    input  rd_fifo, accum_en, wr_ram, ram_addr, restart_avg, ram_full, busy, state_dbg
  );
endinterface

// File: rtl/avg_seq_ctrl.sv
// Windowed averaging sequencer: drains AVG_LEN FIFO samples into the accumulator, writes the
// result to RAM at an auto-incrementing address, then clears. Macro ADDR_WRAP_EN: wrap instead of halt.
module avg_seq_ctrl #(
  parameter int AVG_LEN = 4,
  parameter int ADDR_W  = 8
) (
  input  logic           clk,
  input  logic           reset,
  avg_seq_ctrl_if.master bus
);
  localparam int CNT_W = $clog2(AVG_LEN + 1);
  localparam logic [CNT_W-1:0] LEN  = CNT_W'(AVG_LEN);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(AVG_LEN - 1);
`ifndef ADDR_WRAP_EN
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
`endif

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ACCUM = 3'd1,
    S_WRITE = 3'd2,
    S_CLEAR = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  rd_cnt;
  logic [CNT_W-1:0]  add_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic              accum_en_q;
  logic              wr_ram_q;
  logic              restart_q;
  logic              ram_full_q;
  logic              busy_q;
  logic              rd_fifo_c;

  // Read gating on rd_cnt guarantees no more than AVG_LEN reads per window.
  assign rd_fifo_c = (state == S_ACCUM) && !bus.empty_flag && (rd_cnt < LEN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      rd_cnt     <= '0;
      add_cnt    <= '0;
      addr_q     <= '0;
      accum_en_q <= 1'b0;
      wr_ram_q   <= 1'b0;
      restart_q  <= 1'b0;
      ram_full_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      accum_en_q <= rd_fifo_c;
      wr_ram_q   <= 1'b0;
      restart_q  <= 1'b0;
      if (rd_fifo_c) rd_cnt <= rd_cnt + CNT_W'(1);
      if (accum_en_q) add_cnt <= add_cnt + CNT_W'(1);

      case (state)
        S_IDLE: begin
          if (bus.enable) begin
            state  <= S_ACCUM;
            busy_q <= 1'b1;
          end
        end
        S_ACCUM: begin
          // The last add lands one cycle after the last read; the window closes on it.
          if (accum_en_q && (add_cnt == LAST)) begin
            state    <= S_WRITE;
            wr_ram_q <= 1'b1;
          end
        end
        S_WRITE: begin
          state     <= S_CLEAR;
          restart_q <= 1'b1;
        end
        S_CLEAR: begin
          rd_cnt  <= '0;
          add_cnt <= '0;
`ifdef ADDR_WRAP_EN
          addr_q <= addr_q + ADDR_W'(1);
          if (bus.enable) begin
            state <= S_ACCUM;
          end else begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
          end
`else
          if (addr_q == ADDR_MAX) begin
            state      <= S_HALT;
            ram_full_q <= 1'b1;
          end else begin
            addr_q <= addr_q + ADDR_W'(1);
            if (bus.enable) begin
              state <= S_ACCUM;
            end else begin
              state  <= S_IDLE;
              busy_q <= 1'b0;
            end
          end
`endif
        end
        S_HALT: begin
          state <= S_HALT;
        end
        default: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rd_fifo     = rd_fifo_c;
  assign bus.accum_en    = accum_en_q;
  assign bus.wr_ram      = wr_ram_q;
  assign bus.ram_addr    = addr_q;
  assign bus.restart_avg = restart_q;
  assign bus.ram_full    = ram_full_q;
  assign bus.busy        = busy_q;
  assign bus.state_dbg   = state;
endmodule
